gray_decode_scheduler: RTL and testbench

//   Shares one pipelined gray-to-binary decoder between NCH requesters (TDC/readout

---
 rtl/gray_decode_scheduler_if.sv | 26 ++
 rtl/gray_decode_scheduler.sv | 118 +++++++++++
 tb/tb_gray_decode_scheduler.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/gray_decode_scheduler_if.sv
// Request/response bundle for the shared gray-to-binary decoder.
// The master side owns the requests and out_ready. The slave side is the scheduler.
interface gray_decode_scheduler_if #(
  parameter int N   = 5,
  parameter int NCH = 4,
  parameter int IDW = 2
);
  logic [NCH-1:0]   req_valid;
  logic [NCH*N-1:0] req_gray;
  logic [NCH-1:0]   req_ready;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     out_bin;
  logic [IDW-1:0]   out_ch;
  logic             out_step_err;

  modport master (
    output req_valid, req_gray, out_ready,
    input  req_ready, out_valid, out_bin, out_ch, out_step_err
  );

  modport slave (
    input  req_valid, req_gray, out_ready,
    output req_ready, out_valid, out_bin, out_ch, out_step_err
  );
endinterface

// File: rtl/gray_decode_scheduler.sv
// Round-robin scheduler feeding one two-stage gray-to-binary decoder.
// It also flags any per-channel sample that moves more than one gray step.
module gray_decode_scheduler #(
  parameter int N   = 5,
  parameter int NCH = 4,
  parameter int IDW = 2
) (
  input logic               clk,
  input logic               reset,
  gray_decode_scheduler_if.slave bus
);

  // S1 stage: the accepted word, not yet decoded
  logic           s1_v;
  logic [N-1:0]   s1_gray;
  logic [IDW-1:0] s1_ch;
  logic           s1_err;

  // S2 stage: the output register
  logic           s2_v;
  logic [N-1:0]   s2_bin;
  logic [IDW-1:0] s2_ch;
  logic           s2_err;

  // Per-channel history and arbiter pointer
  logic [N-1:0]   last_gray [NCH];
  logic [NCH-1:0] seen;
  logic [IDW-1:0] rr_ptr;

  logic           s2_load;
  logic           s1_free;
  logic           grant;
  logic [IDW-1:0] grant_ch;
  logic [NCH-1:0] ready;
  logic [N-1:0]   grant_gray;
  logic [N-1:0]   step_d;
  logic           grant_err;

  function automatic logic [N-1:0] g2b(input logic [N-1:0] g);
    logic [N-1:0] b;
    b[N-1] = g[N-1];
    for (int i = N - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  function automatic logic [IDW-1:0] rr_next(input logic [IDW-1:0] p, input int k);
    int s;
    s = (int'(p) + k) % NCH;
    return IDW'(s);
  endfunction

  assign s2_load = s1_v & (~s2_v | bus.out_ready);
  assign s1_free = ~s1_v | s2_load;

  // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    grant    = 1'b0;
    grant_ch = '0;
    for (int k = 1; k <= NCH; k++) begin
      if (!grant && bus.req_valid[rr_next(rr_ptr, k)]) begin
        grant    = 1'b1;
        grant_ch = rr_next(rr_ptr, k);
      end
    end
    grant = grant & s1_free;
  end

  always_comb begin
    ready = '0;
    if (grant) ready[grant_ch] = 1'b1;
  end

  assign grant_gray = bus.req_gray[int'(grant_ch)*N +: N];
  assign step_d     = grant_gray ^ last_gray[grant_ch];
  // A repeat or a single-bit change is legal. d & (d-1) is nonzero only when two or more bits differ.
  assign grant_err  = seen[grant_ch] & (|(step_d & (step_d - N'(1))));

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_v    <= 1'b0;
      s1_gray <= '0;
      s1_ch   <= '0;
      s1_err  <= 1'b0;
      s2_v    <= 1'b0;
      s2_bin  <= '0;
      s2_ch   <= '0;
      s2_err  <= 1'b0;
      seen    <= '0;
      rr_ptr  <= IDW'(NCH - 1);
      // NOTE: the history array is small and feeds the step check, so it is cleared by reset.
      for (int i = 0; i < NCH; i++) last_gray[i] <= '0;
    end else begin
      s1_v <= grant | (s1_v & ~s2_load);
      if (grant) begin
        s1_gray             <= grant_gray;
        s1_ch               <= grant_ch;
        s1_err              <= grant_err;
        last_gray[grant_ch] <= grant_gray;
        seen[grant_ch]      <= 1'b1;
        rr_ptr              <= grant_ch;
      end
      s2_v <= s2_load | (s2_v & ~bus.out_ready);
      if (s2_load) begin
        s2_bin <= g2b(s1_gray);
        s2_ch  <= s1_ch;
        s2_err <= s1_err;
      end
    end
  end

  assign bus.req_ready    = ready;
  assign bus.out_valid    = s2_v;
  assign bus.out_bin      = s2_bin;
  assign bus.out_ch       = s2_ch;
  assign bus.out_step_err = s2_err;

endmodule

// File: tb/tb_gray_decode_scheduler.sv
// Directed bench for gray_decode_scheduler. It covers decode, round-robin order,
// backpressure, the step check, wrap-around and mid-flight reset.
module tb_gray_decode_scheduler;
  localparam int N   = 5;
  localparam int NCH = 4;
  localparam int IDW = 2;

  typedef struct {
    logic [N-1:0]   bin;
    logic [IDW-1:0] ch;
    logic           err;
  } out_rec_t;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  out_rec_t       outq[$];
  logic [IDW-1:0] grantq[$];

  gray_decode_scheduler_if #(.N(N), .NCH(NCH), .IDW(IDW)) bus ();

  gray_decode_scheduler #(.N(N), .NCH(NCH), .IDW(IDW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Record transfers in mid-cycle, when the inputs and DUT outputs are stable.
  always @(negedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NCH; i++)
        if (bus.req_valid[i] && bus.req_ready[i]) grantq.push_back(IDW'(i));
      if (bus.out_valid && bus.out_ready) begin
        out_rec_t r;
        r.bin = bus.out_bin;
        r.ch  = bus.out_ch;
        r.err = bus.out_step_err;
        outq.push_back(r);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [N-1:0] gray_of(input int v);
    logic [N-1:0] b;
    b = N'(v);
    return b ^ (b >> 1);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    outq.delete();
    grantq.delete();
  endtask

  // Sends one word on channel ch and checks the decoded result.
  task automatic send_one(input string tag, input int ch, input logic [N-1:0] g,
                          input int exp_bin, input logic exp_err);
    int n;
    outq.delete();
    bus.req_gray[ch*N +: N] = g;
    bus.req_valid = NCH'(1) << ch;
    #1;
    n = 0;
    while (!bus.req_ready[ch] && n < 20) begin
      step();
      n++;
    end
    check({tag, "_grant_to"}, 32'(n < 20), 32'd1);
    step();
    bus.req_valid = '0;
    n = 0;
    while (outq.size() == 0 && n < 20) begin
      step();
      n++;
    end
    check({tag, "_out_to"}, 32'(outq.size() > 0), 32'd1);
    if (outq.size() > 0) begin
      check({tag, "_bin"}, 32'(outq[0].bin), 32'(exp_bin));
      check({tag, "_ch"},  32'(outq[0].ch),  32'(ch));
      check({tag, "_err"}, 32'(outq[0].err), 32'(exp_err));
    end
  endtask

  task automatic drain(input int cycles);
    bus.req_valid = '0;
    bus.out_ready = 1'b1;
    repeat (cycles) step();
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_gray  = '0;
    bus.out_ready = 1'b1;
    reset         = 1'b1;
    #2;
    do_reset();

    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_bin",   32'(bus.out_bin), 32'd0);
    check("rst_out_ch",    32'(bus.out_ch), 32'd0);
    check("rst_out_err",   32'(bus.out_step_err), 32'd0);
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);

    // T1: exact latency for a single word on ch0
    bus.req_gray[0 +: N] = 5'b00110;
    bus.req_valid = 4'b0001;
    #1;
    check("t1_ready", 32'(bus.req_ready), 32'h1);
    step();
    bus.req_valid = '0;
    check("t1_lat1_valid", 32'(bus.out_valid), 32'd0);
    step();
    check("t1_lat2_valid", 32'(bus.out_valid), 32'd1);
    check("t1_bin", 32'(bus.out_bin), 32'd4);
    check("t1_ch",  32'(bus.out_ch), 32'd0);
    check("t1_err", 32'(bus.out_step_err), 32'd0);
    drain(3);

    for (int v = 0; v < 32; v++)
      send_one($sformatf("t1_sweep%0d", v), 1, gray_of(v), v, 1'b0);

    // T2: round-robin with every channel requesting
    do_reset();
    for (int i = 0; i < NCH; i++) bus.req_gray[i*N +: N] = gray_of(i + 1);
    bus.req_valid = 4'b1111;
    #1;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("t2_ready%0d", k), 32'(bus.req_ready), 32'(1 << (k % 4)));
      step();
    end
    drain(5);
    check("t2_ngrant", 32'(grantq.size()), 32'd8);
    check("t2_nout",   32'(outq.size()), 32'd8);
    for (int k = 0; k < 8; k++) begin
      if (k < grantq.size()) check($sformatf("t2_gch%0d", k), 32'(grantq[k]), 32'(k % 4));
      if (k < outq.size()) begin
        check($sformatf("t2_och%0d", k),  32'(outq[k].ch),  32'(k % 4));
        check($sformatf("t2_obin%0d", k), 32'(outq[k].bin), 32'(k % 4 + 1));
        check($sformatf("t2_oerr%0d", k), 32'(outq[k].err), 32'd0);
      end
    end

    // T3: backpressure with every channel requesting
    do_reset();
    bus.out_ready = 1'b0;
    bus.req_valid = 4'b1111;
    #1;
    for (int k = 0; k < 5; k++) begin
      if (k >= 2) begin
        check($sformatf("t3_stall_ready%0d", k), 32'(bus.req_ready), 32'd0);
        check($sformatf("t3_stall_valid%0d", k), 32'(bus.out_valid), 32'd1);
        check($sformatf("t3_stall_ch%0d", k),    32'(bus.out_ch), 32'd0);
        check($sformatf("t3_stall_bin%0d", k),   32'(bus.out_bin), 32'd1);
      end
      step();
    end
    check("t3_ngrant", 32'(grantq.size()), 32'd2);
    check("t3_ready_end", 32'(bus.req_ready), 32'd0);
    check("t3_nout_stall", 32'(outq.size()), 32'd0);
    drain(5);
    check("t3_nout", 32'(outq.size()), 32'd2);
    for (int k = 0; k < 2; k++) begin
      if (k < outq.size()) begin
        check($sformatf("t3_och%0d", k),  32'(outq[k].ch),  32'(k));
        check($sformatf("t3_obin%0d", k), 32'(outq[k].bin), 32'(k + 1));
      end
    end

    // T4: step error on ch2
    send_one("t4_a", 2, 5'b00000, 0, 1'b0);
    send_one("t4_b", 2, 5'b00001, 1, 1'b0);
    send_one("t4_c", 2, 5'b00011, 2, 1'b0);
    send_one("t4_d", 2, 5'b00000, 0, 1'b1);
    send_one("t4_e", 2, 5'b10001, 30, 1'b1);
    send_one("t4_f", 2, 5'b10000, 31, 1'b0);

    // T5: wrap-around and repeat on ch3
    send_one("t5_a", 3, 5'b10000, 31, 1'b0);
    send_one("t5_b", 3, 5'b00000, 0, 1'b0);
    send_one("t5_c", 3, 5'b00000, 0, 1'b0);

    // T6: reset with S1 and S2 both full
    for (int i = 0; i < NCH; i++) bus.req_gray[i*N +: N] = 5'b01110;
    bus.out_ready = 1'b0;
    bus.req_valid = 4'b1111;
    step();
    step();
    check("t6_pre_valid", 32'(bus.out_valid), 32'd1);
    check("t6_pre_ready", 32'(bus.req_ready), 32'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.out_ready = 1'b1;
    outq.delete();
    grantq.delete();
    check("t6_valid", 32'(bus.out_valid), 32'd0);
    check("t6_ready", 32'(bus.req_ready), 32'h1);
    repeat (4) step();
    drain(5);
    check("t6_nout", 32'(outq.size()), 32'd4);
    for (int k = 0; k < 4; k++) begin
      if (k < outq.size()) begin
        check($sformatf("t6_och%0d", k),  32'(outq[k].ch),  32'(k));
        check($sformatf("t6_obin%0d", k), 32'(outq[k].bin), 32'd11);
        check($sformatf("t6_oerr%0d", k), 32'(outq[k].err), 32'd0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
